// File: rtl/xadac_dispatch_mux.sv
// Mask/match dispatch of CV-X-IF requests to NoUnits XADAC units with per-unit in-flight caps,
// plus a locking response arbiter. Define XADAC_DISPATCH_ROUND_ROBIN_EN for rotating response priority.

module xadac_dispatch_cnt #(
    parameter int MaxOutstanding = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic inc,
    input  logic dec,
    output logic full
);
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    logic [CntWidth-1:0] cnt;

    // Simultaneous inc/dec cancels; a stray dec at zero saturates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full = (cnt == CntWidth'(MaxOutstanding));

    a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rstn) dec |-> cnt != '0)
        else $error("xadac_dispatch_mux: response from a unit with no outstanding request");
endmodule

module xadac_dispatch_mux #(
    parameter int                    NoUnits        = 4,
    parameter int                    IdWidth        = 3,
    parameter int                    ReqWidth       = 448,
    parameter int                    RespWidth      = 162,
    parameter logic [NoUnits*32-1:0] MaskTable      = '0,
    parameter logic [NoUnits*32-1:0] MatchTable     = '0,
    parameter int                    MaxOutstanding = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              slv_req_valid,
    output logic                              slv_req_ready,
    input  logic [31:0]                       slv_req_instr,
    input  logic [IdWidth-1:0]                slv_req_id,
    input  logic [ReqWidth-1:0]               slv_req_data,
    output logic [6:0]                        slv_req_flags,
    output logic                              slv_req_accept,
    output logic                              slv_resp_valid,
    input  logic                              slv_resp_ready,
    output logic [IdWidth-1:0]                slv_resp_id,
    output logic [RespWidth-1:0]              slv_resp_data,
    output logic [NoUnits-1:0]                unit_req_valid,
    input  logic [NoUnits-1:0]                unit_req_ready,
    output logic [31:0]                       unit_req_instr,
    output logic [IdWidth-1:0]                unit_req_id,
    output logic [ReqWidth-1:0]               unit_req_data,
    input  logic [NoUnits-1:0][6:0]           unit_req_flags,
    input  logic [NoUnits-1:0]                unit_req_accept,
    input  logic [NoUnits-1:0]                unit_resp_valid,
    output logic [NoUnits-1:0]                unit_resp_ready,
    input  logic [NoUnits-1:0][IdWidth-1:0]   unit_resp_id,
    input  logic [NoUnits-1:0][RespWidth-1:0] unit_resp_data
);
    localparam int UnitWidth = (NoUnits > 1) ? $clog2(NoUnits) : 1;

    typedef logic [UnitWidth-1:0] unit_t;
    typedef enum logic {IDLE, LOCKED} arb_state_e;
    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [RespWidth-1:0] data;
    } resp_t;

    logic [NoUnits-1:0] hit, full, inc, dec;
    logic               req_hit;
    unit_t              req_sel;

    for (genvar i = 0; i < NoUnits; i++) begin : g_unit
        assign hit[i] = (slv_req_instr & MaskTable[32*i +: 32]) == MatchTable[32*i +: 32];
        assign inc[i] = unit_req_valid[i] & unit_req_ready[i] & unit_req_accept[i];
        assign dec[i] = unit_resp_valid[i] & unit_resp_ready[i];

        xadac_dispatch_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt (
            .clk  (clk),
            .rstn (rstn),
            .inc  (inc[i]),
            .dec  (dec[i]),
            .full (full[i])
        );
    end

    // Lowest-index hit wins when table entries overlap.
    always_comb begin
        req_hit = 1'b0;
        req_sel = '0;
        for (int i = NoUnits - 1; i >= 0; i--) begin
            if (hit[i]) begin
                req_hit = 1'b1;
                req_sel = unit_t'(i);
            end
        end
    end

    always_comb begin
        unit_req_valid = '0;
        slv_req_ready  = 1'b0;
        slv_req_accept = 1'b0;
        slv_req_flags  = '0;
        if (slv_req_valid) begin
            if (!req_hit) begin
                slv_req_ready = 1'b1;
            end else if (!full[req_sel]) begin
                unit_req_valid[req_sel] = 1'b1;
                slv_req_ready           = unit_req_ready[req_sel];
                slv_req_accept          = unit_req_accept[req_sel];
                slv_req_flags           = unit_req_flags[req_sel];
            end
        end
    end

    assign unit_req_instr = slv_req_instr;
    assign unit_req_id    = slv_req_id;
    assign unit_req_data  = slv_req_data;

    arb_state_e state_q, state_d;
    unit_t      sel_q, sel_d, search, grant;
    resp_t      resp;
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
    unit_t      rr_q, rr_d;
`endif

    // First valid unit in priority order; reverse scan so the nearest candidate wins.
    always_comb begin
        int idx;
        idx    = 0;
        search = '0;
        for (int k = NoUnits - 1; k >= 0; k--) begin
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
            idx = int'(rr_q) + k;
            if (idx >= NoUnits) idx = idx - NoUnits;
`else
            idx = k;
`endif
            if (unit_resp_valid[unit_t'(idx)]) search = unit_t'(idx);
        end
    end

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
        rr_d            = rr_q;
`endif
        grant           = (state_q == LOCKED) ? sel_q : search;
        slv_resp_valid  = unit_resp_valid[grant];
        unit_resp_ready = '0;
        resp            = '0;
        if (slv_resp_valid) begin
            unit_resp_ready[grant] = slv_resp_ready;
            resp.id                = unit_resp_id[grant];
            resp.data              = unit_resp_data[grant];
        end
        case (state_q)
            IDLE: begin
                if (slv_resp_valid && !slv_resp_ready) begin
                    state_d = LOCKED;
                    sel_d   = grant;
                end
            end
            LOCKED: begin
                if (slv_resp_valid && slv_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
        if (slv_resp_valid && slv_resp_ready) begin
            if (int'(grant) >= NoUnits - 1) rr_d = '0;
            else                            rr_d = grant + 1'b1;
        end
`endif
    end

    assign slv_resp_id   = resp.id;
    assign slv_resp_data = resp.data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sel_q   <= '0;
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef XADAC_DISPATCH_ROUND_ROBIN_EN
            rr_q    <= rr_d;
`endif
        end
    end
endmodule
